// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson step controller: command encodings, FSM
// state type and a helper that gives the N-bit Johnson code at an up-sequence index.
package johnson_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'b00,
    OP_RUN_N    = 2'b01,
    OP_RUN_FREE = 2'b10,
    OP_ABORT    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int MAX_N = 16;

  // Index k <= n has k ones packed against the MSB; index k > n has 2n-k ones packed against the LSB.
  function automatic logic [MAX_N-1:0] johnson_code(input int n, input int k);
    logic [MAX_N-1:0] code;
    code = '0;
    for (int b = 0; b < MAX_N; b++) begin
      if (b < n) begin
        if (k <= n) code[b] = (b >= n - k);
        else        code[b] = (b < 2 * n - k);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// N-bit Johnson shift register with up/down stepping and synchronous clear.
// A step taken from a non-Johnson code loads zero instead of shifting.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic         dir,
  output logic [N-1:0] q
);

  logic [N-1:0]     q_r;
  logic [N-1:0]     q_next;
  logic [MAX_N-1:0] code_k;
  logic             legal;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    legal  = 1'b0;
    code_k = '0;
    for (int k = 0; k < 2 * N; k++) begin
      code_k = johnson_code(N, k);
      if (q_r == code_k[N-1:0]) legal = 1'b1;
    end

    q_next = q_r;
    if (clr) begin
      q_next = '0;
    end else if (step) begin
      if (!legal)   q_next = '0;
      else if (dir) q_next = {q_r[N-2:0], ~q_r[N-1]};
      else          q_next = {~q_r[0], q_r[N-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (clr || step) begin
      q_r <= q_next;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven Johnson counter controller: IDLE/RUN/DONE FSM, step counter
// and phase decode around a johnson_core shift register.
module johnson_step_ctrl
  import johnson_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  localparam int PH_W = $clog2(2 * N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  output logic [N-1:0]     q,
  output logic [PH_W-1:0]  phase,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state, state_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             free_run, free_run_next;
  logic             run_dir, run_dir_next;
  logic             err_r;
  logic             accept, clr, step, reject, phase_ok;
  logic [MAX_N-1:0] code_k;
  op_e              op;

  johnson_core #(.N(N)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .step  (step),
    .dir   (run_dir),
    .q     (q)
  );

  // Phase is the up-sequence index of q; no match means q holds an illegal code.
  always_comb begin
    phase    = '0;
    phase_ok = 1'b0;
    code_k   = '0;
    for (int k = 0; k < 2 * N; k++) begin
      code_k = johnson_code(N, k);
      if (q == code_k[N-1:0]) begin
        phase    = PH_W'(k);
        phase_ok = 1'b1;
      end
    end
  end

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state != ST_DONE);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    free_run_next  = free_run;
    run_dir_next   = run_dir;
    clr            = 1'b0;
    step           = 1'b0;
    reject         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_CLEAR: clr = 1'b1;
            OP_RUN_N: begin
              run_dir_next  = cmd_dir;
              free_run_next = 1'b0;
              if (cmd_steps == '0) begin
                state_next = ST_DONE;
              end else begin
                state_next     = ST_RUN;
                remaining_next = cmd_steps;
              end
            end
            OP_RUN_FREE: begin
              run_dir_next  = cmd_dir;
              free_run_next = 1'b1;
              state_next    = ST_RUN;
            end
            default: reject = 1'b1;
          endcase
        end
      end
      ST_RUN: begin
        if (accept && op == OP_ABORT) begin
          state_next = ST_DONE;
        end else begin
          // Any other command is swallowed; the run itself is undisturbed.
          step   = 1'b1;
          reject = accept;
          if (!free_run) begin
            remaining_next = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) state_next = ST_DONE;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: only control registers are reset; there is no memory here that would need a reset-free array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      free_run  <= 1'b0;
      run_dir   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      free_run  <= free_run_next;
      run_dir   <= run_dir_next;
      err_r     <= reject || (step && !phase_ok);
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign err  = err_r;

endmodule
